// File: rtl/la_capture_core_if.sv
// Probe, trigger, control and readout bundle for la_capture_core.
// trig_edge_i exists only when LA_CAPTURE_EDGE_TRIG_EN is defined.
interface la_capture_core_if #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 256
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] probe_i;
    logic              arm_i;
    logic              abort_i;
    logic [DATA_W-1:0] trig_mask_i;
    logic [DATA_W-1:0] trig_value_i;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
    logic [DATA_W-1:0] trig_edge_i;
`endif
    logic [AW-1:0]     pretrig_i;
    logic [AW-1:0]     rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              armed_o;
    logic              triggered_o;
    logic              done_o;
    logic [AW-1:0]     trig_pos_o;

    modport master (
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        output trig_edge_i,
`endif
        output probe_i, arm_i, abort_i, trig_mask_i, trig_value_i, pretrig_i, rd_addr_i,
        input  rd_data_o, armed_o, triggered_o, done_o, trig_pos_o
    );

    modport slave (
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        input  trig_edge_i,
`endif
        input  probe_i, arm_i, abort_i, trig_mask_i, trig_value_i, pretrig_i, rd_addr_i,
        output rd_data_o, armed_o, triggered_o, done_o, trig_pos_o
    );
endinterface

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture into a DEPTH-entry circular buffer with masked trigger, pre-trigger depth, abort.
// Latency: probe written every clk in PRE/WAIT/POST; rd_data_o = mem[start + rd_addr_i] one cycle after rd_addr_i.
// Backpressure: none, capture is free-running; LA_CAPTURE_EDGE_TRIG_EN adds per-bit edge triggering via trig_edge_i.
module la_capture_core #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    la_capture_core_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     p_q, p_d;
    logic [AW-1:0]     taddr_q, taddr_d;
    logic              trig_q, trig_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              capturing;
    logic              hit;
    logic [AW-1:0]     start;
    logic [AW-1:0]     rd_idx;

`ifdef LA_CAPTURE_EDGE_TRIG_EN
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] bit_eq, bit_edge, bit_ok;

    always_comb begin
        prev_d   = bus.probe_i;
        bit_eq   = ~(bus.probe_i ^ bus.trig_value_i);
        // Edge bits need the previous sample to differ from the target value.
        bit_edge = bit_eq & (prev_q ^ bus.trig_value_i);
        bit_ok   = (bus.trig_edge_i & bit_edge) | (~bus.trig_edge_i & bit_eq);
        hit      = &(bit_ok | ~bus.trig_mask_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= prev_d;
    end
`else
    always_comb begin
        hit = ((bus.probe_i ^ bus.trig_value_i) & bus.trig_mask_i) == '0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        taddr_d   = taddr_q;
        trig_d    = trig_q;
        capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        if (capturing) wptr_d = wptr_q + AW'(1);

        // ~p_q is DEPTH-P-1 in AW bits: the number of samples written after the trigger sample.
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.arm_i) begin
                    // An AW-bit pretrig can never exceed DEPTH-1, so it is already the effective value.
                    p_d     = bus.pretrig_i;
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (bus.pretrig_i != '0) ? S_PRE : S_WAIT;
                end
            end
            S_PRE: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == p_q - AW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (hit) begin
                    taddr_d = wptr_q;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (~p_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == ~p_q - AW'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort_i) begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
        end

        start     = taddr_q - p_q;
        rd_idx    = start + bus.rd_addr_i;
        rd_data_d = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            taddr_q   <= '0;
            trig_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            taddr_q   <= taddr_d;
            trig_q    <= trig_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sample memory carries no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (capturing) mem[wptr_q] <= bus.probe_i;
    end

    assign bus.armed_o     = capturing;
    assign bus.triggered_o = trig_q;
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.trig_pos_o  = p_q;
    assign bus.rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core at DATA_W=8, DEPTH=16; readout expectations go through a scoreboard queue.
module tb_la_capture_core;
    localparam int DW  = 8;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_tab [DEP];

    la_capture_core_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();
    la_capture_core #(.DATA_W(DW), .DEPTH(DEP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives addresses 0..DEPTH-1 and compares each registered word against exp_tab.
    task automatic readout(input string name);
        logic [DW-1:0] e;
        for (int i = 0; i < DEP; i++) begin
            bus.rd_addr_i = 4'(i);
            exp_q.push_back(exp_tab[i]);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (bus.rd_data_o !== e) begin
                tests_failed++;
                $display("FAIL %s rd[%0d]: got %0h expected %0h", name, i, bus.rd_data_o, e);
            end
        end
    endtask

    task automatic run_count_capture(input string name, input int p, input int tv);
        int trig_at = -1;
        int done_at = -1;
        bus.pretrig_i = 4'(p);
        bus.trig_mask_i = 8'hFF;
        bus.trig_value_i = 8'(tv);
        bus.probe_i = 8'h00;
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        tests_run++;
        if (bus.armed_o !== 1'b1 || bus.done_o !== 1'b0 || bus.triggered_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s arm status: got a%b t%b d%b expected a1 t0 d0", name,
                     bus.armed_o, bus.triggered_o, bus.done_o);
        end
        for (int k = 1; k < 60; k++) begin
            bus.probe_i = 8'(k);
            tick();
            if (trig_at < 0 && bus.triggered_o === 1'b1) trig_at = k;
            if (bus.done_o === 1'b1) begin
                done_at = k;
                break;
            end
        end
        tests_run++;
        if (trig_at != tv) begin
            tests_failed++;
            $display("FAIL %s trigger sample: got %0d expected %0d", name, trig_at, tv);
        end
        tests_run++;
        if (done_at != tv + (DEP - 1 - p)) begin
            tests_failed++;
            $display("FAIL %s done sample: got %0d expected %0d", name, done_at, tv + (DEP - 1 - p));
        end
        tests_run++;
        if (bus.trig_pos_o !== 4'(p)) begin
            tests_failed++;
            $display("FAIL %s trig_pos: got %0d expected %0d", name, bus.trig_pos_o, p);
        end
        for (int i = 0; i < DEP; i++) exp_tab[i] = 8'(tv - p + i);
        readout(name);
        tests_run++;
        if (bus.done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s done held: got %b expected 1", name, bus.done_o);
        end
    endtask

    task automatic test_reset();
        bus.probe_i = '0; bus.arm_i = 0; bus.abort_i = 0; bus.trig_mask_i = '0;
        bus.trig_value_i = '0; bus.pretrig_i = '0; bus.rd_addr_i = '0;
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        bus.trig_edge_i = '0;
`endif
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        tests_run++;
        if ({bus.armed_o, bus.triggered_o, bus.done_o} !== 3'b000 || bus.trig_pos_o !== 4'd0
            || bus.rd_data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset: got a%b t%b d%b pos%0d rd%0h expected all 0", bus.armed_o,
                     bus.triggered_o, bus.done_o, bus.trig_pos_o, bus.rd_data_o);
        end
    endtask

    task automatic test_p_zero();
        int done_at = -1;
        bus.pretrig_i = 4'd0; bus.trig_mask_i = 8'h00; bus.trig_value_i = 8'h77;
        bus.probe_i = 8'h40; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        tests_run++;
        if (bus.triggered_o !== 1'b0 || bus.armed_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL p0 after arm: got t%b a%b expected t0 a1", bus.triggered_o, bus.armed_o);
        end
        bus.probe_i = 8'h50;
        tick();
        tests_run++;
        if (bus.triggered_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL p0 trigger: got %b expected 1", bus.triggered_o);
        end
        for (int k = 1; k < 40; k++) begin
            bus.probe_i = 8'(8'h50 + k);
            tick();
            if (bus.done_o === 1'b1) begin
                done_at = k;
                break;
            end
        end
        tests_run++;
        if (done_at != 15) begin
            tests_failed++;
            $display("FAIL p0 done: got %0d expected 15", done_at);
        end
        for (int i = 0; i < DEP; i++) exp_tab[i] = 8'(8'h50 + i);
        readout("p0");
    endtask

    task automatic test_max_pretrig();
        bus.pretrig_i = 4'd15; bus.trig_mask_i = 8'hFF; bus.trig_value_i = 8'h12;
        bus.probe_i = 8'h12; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            bus.probe_i = 8'(8'h10 + k);
            tick();
        end
        bus.probe_i = 8'h30; tick();
        bus.probe_i = 8'h31; tick();
        tests_run++;
        if (bus.triggered_o !== 1'b0 || bus.armed_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL maxpre no-trigger-in-pre: got t%b a%b expected t0 a1", bus.triggered_o, bus.armed_o);
        end
        bus.probe_i = 8'h12;
        tick();
        tests_run++;
        if (bus.triggered_o !== 1'b1 || bus.done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL maxpre done-next: got t%b d%b expected t1 d1", bus.triggered_o, bus.done_o);
        end
        tests_run++;
        if (bus.trig_pos_o !== 4'd15) begin
            tests_failed++;
            $display("FAIL maxpre trig_pos: got %0d expected 15", bus.trig_pos_o);
        end
        for (int i = 0; i < 13; i++) exp_tab[i] = 8'(8'h12 + i);
        exp_tab[13] = 8'h30; exp_tab[14] = 8'h31; exp_tab[15] = 8'h12;
        readout("maxpre");
    endtask

    task automatic test_abort();
        bus.pretrig_i = 4'd2; bus.trig_mask_i = 8'hFF; bus.trig_value_i = 8'h05;
        bus.probe_i = 8'h00; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int k = 1; k < 8; k++) begin
            bus.probe_i = 8'(k);
            tick();
        end
        tests_run++;
        if (bus.armed_o !== 1'b1 || bus.triggered_o !== 1'b1 || bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort in-post: got a%b t%b d%b expected a1 t1 d0", bus.armed_o,
                     bus.triggered_o, bus.done_o);
        end
        bus.abort_i = 1'b1;
        tick();
        tests_run++;
        if ({bus.armed_o, bus.triggered_o, bus.done_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort: got a%b t%b d%b expected 000", bus.armed_o, bus.triggered_o, bus.done_o);
        end
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0; bus.abort_i = 1'b0;
        tests_run++;
        if ({bus.armed_o, bus.triggered_o, bus.done_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort-over-arm: got a%b t%b d%b expected 000", bus.armed_o, bus.triggered_o, bus.done_o);
        end
        run_count_capture("after-abort", 4, 8'h0A);
    endtask

    task automatic test_reset_mid();
        bus.pretrig_i = 4'd1; bus.trig_mask_i = 8'hFF; bus.trig_value_i = 8'hEE;
        bus.probe_i = 8'h00; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int k = 1; k < 4; k++) begin
            bus.probe_i = 8'(k);
            tick();
        end
        tests_run++;
        if (bus.armed_o !== 1'b1 || bus.trig_pos_o !== 4'd1) begin
            tests_failed++;
            $display("FAIL midreset pre: got a%b pos%0d expected a1 pos1", bus.armed_o, bus.trig_pos_o);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.armed_o, bus.triggered_o, bus.done_o} !== 3'b000 || bus.trig_pos_o !== 4'd0
            || bus.rd_data_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset async: got a%b t%b d%b pos%0d rd%0h expected all 0", bus.armed_o,
                     bus.triggered_o, bus.done_o, bus.trig_pos_o, bus.rd_data_o);
        end
        tick();
        reset_n = 1'b1;
        tick();
        run_count_capture("wrap", 3, 8'h07);
    endtask

`ifdef LA_CAPTURE_EDGE_TRIG_EN
    task automatic test_edge();
        int done_at = -1;
        bus.pretrig_i = 4'd0; bus.trig_mask_i = 8'h01; bus.trig_value_i = 8'h01;
        bus.trig_edge_i = 8'h01; bus.probe_i = 8'h01; bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        bus.probe_i = 8'h03; tick();
        bus.probe_i = 8'h05; tick();
        bus.probe_i = 8'h06; tick();
        tests_run++;
        if (bus.triggered_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge held-high: got %b expected 0", bus.triggered_o);
        end
        bus.probe_i = 8'h09;
        tick();
        tests_run++;
        if (bus.triggered_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge rising: got %b expected 1", bus.triggered_o);
        end
        for (int k = 1; k < 40; k++) begin
            bus.probe_i = 8'(8'h09 + k);
            tick();
            if (bus.done_o === 1'b1) begin
                done_at = k;
                break;
            end
        end
        tests_run++;
        if (done_at != 15) begin
            tests_failed++;
            $display("FAIL edge done: got %0d expected 15", done_at);
        end
        for (int i = 0; i < DEP; i++) exp_tab[i] = 8'(8'h09 + i);
        readout("edge");
        bus.trig_edge_i = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        run_count_capture("basic", 4, 8'h0A);
        test_p_zero();
        test_max_pretrig();
        test_abort();
        test_reset_mid();
`ifdef LA_CAPTURE_EDGE_TRIG_EN
        test_edge();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
